hazard_stall_unit: RTL and testbench

Pipeline hazard controller between IF/ID and ID/EX, directly upstream of the forwarding unit. Detects load-use hazards and inserts one bubble into ID/EX, so the forwarding unit only sees hazards it can resolve. Flushes IF/ID on a taken branch or jump resolved in ID. Drains the pipeline on a HALT instruction, then reports halted to the debug unit. Keeps a saturating stall-cycle counter that the debug unit can read out.

---
 rtl/hazard_stall_unit_pkg.sv | 19 +
 rtl/hazard_stall_unit_sat_counter.sv | 14 +
 rtl/hazard_stall_unit.sv | 91 +++++++++
 tb/tb_hazard_stall_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall controller and the forwarding unit.
package hazard_stall_unit_pkg;
  localparam int NB_REG = 5;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [NB_REG-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;
endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Width-parameterised saturating up-counter with async active-low clear.
module sat_counter #(
  parameter int W = 16
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              q <= '0;
    else if (en && q != '1)  q <= q + W'(1);
  end
endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, branch flush and HALT drain control between IF/ID and ID/EX.
module hazard_stall_unit #(
  parameter int NB_REG       = 5,
  parameter int NB_COUNT     = 16,
  parameter int DRAIN_CYCLES = 3
)(
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  input  logic                i_restart,
  input  logic [NB_REG-1:0]   i_IF_ID_rs,
  input  logic [NB_REG-1:0]   i_IF_ID_rt,
  input  logic [NB_REG-1:0]   i_ID_EX_rt,
  input  logic                i_ID_EX_mem_read,
  input  logic                i_ID_branch_taken,
  input  logic                i_ID_halt,
  output logic                o_pc_write,
  output logic                o_if_id_write,
  output logic                o_if_id_flush,
  output logic                o_id_ex_bubble,
  output logic                o_halted,
  output logic [NB_COUNT-1:0] o_stall_cycles
);
  import hazard_stall_unit_pkg::*;

  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

  logic [1:0]          state, nxt_state;
  logic [NB_DRAIN-1:0] drain, nxt_drain;
  ctrl_t               ctrl;
  logic                luh;

  assign luh = i_ID_EX_mem_read && (i_ID_EX_rt != NB_REG'(REG_ZERO)) &&
               ((i_ID_EX_rt == i_IF_ID_rs) || (i_ID_EX_rt == i_IF_ID_rt));

  always_comb begin
    ctrl      = CTRL_IDLE;
    nxt_state = state;
    nxt_drain = drain;
    if (i_enable) begin
      case (state)
        ST_RUN: begin
          // load-use wins; a coincident branch/halt re-evaluates after the bubble
          if (luh) begin
            ctrl.id_ex_bubble = 1'b1;
          end else if (i_ID_halt) begin
            nxt_state = ST_DRAIN;
            nxt_drain = NB_DRAIN'(DRAIN_CYCLES);
          end else begin
            ctrl.pc_write    = 1'b1;
            ctrl.if_id_write = 1'b1;
            ctrl.if_id_flush = i_ID_branch_taken;
          end
        end
        ST_DRAIN: begin
          ctrl.id_ex_bubble = 1'b1;
          nxt_drain         = drain - NB_DRAIN'(1);
          if (drain <= NB_DRAIN'(1)) nxt_state = ST_HALTED;
        end
        ST_HALTED: begin
          if (i_restart) nxt_state = ST_RUN;
        end
        default: nxt_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_RUN;
      drain <= '0;
    end else if (i_enable) begin
      state <= nxt_state;
      drain <= nxt_drain;
    end
  end

  // RUN decodes to "advance", so controls are forced low while reset is held
  assign o_pc_write     = ctrl.pc_write     & i_reset_n;
  assign o_if_id_write  = ctrl.if_id_write  & i_reset_n;
  assign o_if_id_flush  = ctrl.if_id_flush  & i_reset_n;
  assign o_id_ex_bubble = ctrl.id_ex_bubble & i_reset_n;
  assign o_halted       = (state == ST_HALTED);

  sat_counter #(.W(NB_COUNT)) u_stall_cnt (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .en    (i_enable && (state == ST_RUN) && luh),
    .q     (o_stall_cycles)
  );
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: vector table, HALT/restart/reset sequences, randomized run vs model.
module tb_hazard_stall_unit;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, restart = 1'b0;
  logic       mr = 1'b0, br = 1'b0, halt = 1'b0;
  logic [4:0] rs = '0, rt = '0, exrt = '0;

  logic        pcw, ifw, fl, bub, hlt;
  logic [15:0] cnt;
  logic        pcw4, ifw4, fl4, bub4, hlt4;
  logic [3:0]  cnt4;

  int checks = 0, errors = 0;

  // reference model: mode 0=run 1=drain 2=halted, plain integer counters
  int m_mode = 0, m_left = 0, m_c16 = 0, m_c4 = 0;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_restart(restart),
    .i_IF_ID_rs(rs), .i_IF_ID_rt(rt), .i_ID_EX_rt(exrt), .i_ID_EX_mem_read(mr),
    .i_ID_branch_taken(br), .i_ID_halt(halt),
    .o_pc_write(pcw), .o_if_id_write(ifw), .o_if_id_flush(fl), .o_id_ex_bubble(bub),
    .o_halted(hlt), .o_stall_cycles(cnt)
  );

  hazard_stall_unit #(.NB_COUNT(4)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_restart(restart),
    .i_IF_ID_rs(rs), .i_IF_ID_rt(rt), .i_ID_EX_rt(exrt), .i_ID_EX_mem_read(mr),
    .i_ID_branch_taken(br), .i_ID_halt(halt),
    .o_pc_write(pcw4), .o_if_id_write(ifw4), .o_if_id_flush(fl4), .o_id_ex_bubble(bub4),
    .o_halted(hlt4), .o_stall_cycles(cnt4)
  );

  function automatic logic m_luh();
    return mr && (exrt != 0) && (exrt == rs || exrt == rt);
  endfunction

  // {pc_write, if_id_write, flush, bubble}
  function automatic logic [3:0] m_ctrl();
    if (!rst_n || !en) return 4'b0000;
    if (m_mode == 1) return 4'b0001;
    if (m_mode == 2) return 4'b0000;
    if (m_luh())     return 4'b0001;
    if (halt)        return 4'b0000;
    if (br)          return 4'b1110;
    return 4'b1100;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_c16 = 0; m_c4 = 0;
  endtask

  task automatic model_step();
    if (!rst_n || !en) return;
    case (m_mode)
      0: if (m_luh()) begin
           m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
           m_c4  = (m_c4 < 15) ? m_c4 + 1 : 15;
         end else if (halt) begin
           m_mode = 1; m_left = 3;
         end
      1: begin
           m_left--;
           if (m_left == 0) m_mode = 2;
         end
      default: if (restart) m_mode = 0;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_now(input string name);
    chk({name, "_ctrl"},   {28'b0, pcw, ifw, fl, bub},     {28'b0, m_ctrl()});
    chk({name, "_halted"}, {31'b0, hlt},                   {31'b0, (m_mode == 2 && rst_n)});
    chk({name, "_cnt"},    {16'b0, cnt},                   m_c16);
    chk({name, "_ctrl4"},  {28'b0, pcw4, ifw4, fl4, bub4}, {28'b0, m_ctrl()});
    chk({name, "_cnt4"},   {28'b0, cnt4},                  m_c4);
  endtask

  // called just after a negedge with inputs already driven
  task automatic step(input string name);
    #1;
    check_now(name);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] x, input logic m, input logic bt,
                       input logic h, input logic rs_q);
    en = e; rs = a; rt = b; exrt = x; mr = m; br = bt; halt = h; restart = rs_q;
  endtask

  typedef struct {
    logic       en;
    logic [4:0] rs, rt, exrt;
    logic       mr, br, halt, restart;
    logic [3:0] ctrl;
    int         cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 0};
    tbl[1]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 1};
    tbl[2]  = '{1'b1, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1};
    tbl[3]  = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 2};
    tbl[4]  = '{1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 2};
    tbl[5]  = '{1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 3};
    tbl[6]  = '{1'b0, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 3};
    tbl[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3};
    tbl[8]  = '{1'b1, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, 3};
    tbl[9]  = '{1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 3};
    tbl[10] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 4};

    model_reset();
    drive(1, 5, 5, 5, 1, 1, 0, 0);
    #3;
    chk("reset_ctrl",   {28'b0, pcw, ifw, fl, bub}, 32'd0);
    chk("reset_halted", {31'b0, hlt}, 32'd0);
    chk("reset_cnt",    {16'b0, cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].rs, tbl[i].rt, tbl[i].exrt, tbl[i].mr, tbl[i].br,
            tbl[i].halt, tbl[i].restart);
      #1;
      chk("tbl_ctrl", {28'b0, pcw, ifw, fl, bub}, {28'b0, tbl[i].ctrl});
      chk("tbl_cnt",  {16'b0, cnt}, tbl[i].cnt);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    // HALT with continuous enable: halted after exactly 4 edges
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step("halt_issue");
    halt = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      #1;
      chk("halt_edges", {31'b0, hlt}, {31'b0, (e == 4)});
      mr = 1'b1; exrt = 5'd2; rs = 5'd2;
      step("drain");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    step("restart_noen");
    #1 chk("restart_noen_halted", {31'b0, hlt}, 32'd1);
    en = 1'b1;
    step("restart_en");
    restart = 1'b0;
    #1;
    chk("restart_pcw",    {31'b0, pcw}, 32'd1);
    chk("restart_halted", {31'b0, hlt}, 32'd0);

    // HALT with two disabled cycles mid-drain
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step("halt2_issue");
    halt = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      #1;
      chk("halt2_edges", {31'b0, hlt}, {31'b0, (e == 6)});
      en = !((e + 1 == 3) || (e + 1 == 4));
      step("drain2");
    end
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    step("restart2");
    restart = 1'b0;

    // asynchronous reset while draining
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step("halt3_issue");
    halt = 1'b0;
    step("drain3");
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_drain_ctrl",   {28'b0, pcw, ifw, fl, bub}, 32'd0);
    chk("rst_drain_halted", {31'b0, hlt}, 32'd0);
    chk("rst_drain_cnt",    {16'b0, cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_drain_run_pcw", {31'b0, pcw}, 32'd1);
    step("post_reset");

    // 20 consecutive load-use stalls: narrow counter must stick at 15
    drive(1, 5'd6, 5'd0, 5'd6, 1, 0, 0, 0);
    for (int k = 0; k < 20; k++) step("sat");
    #1;
    chk("sat_cnt4",  {28'b0, cnt4}, 32'd15);
    chk("sat_cnt16", {16'b0, cnt},  32'd20);

    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
